// File: rtl/oob_device_control.sv
// oob_device_control: device-side SATA OOB responder for a GTP endpoint.
// Waits for host COMRESET, answers COMINIT, waits for host COMWAKE and
// answers COMWAKE, then sends ALIGN until the host returns ALIGNs, sends
// SYNC and declares linkup. After linkup the link-layer TX data is passed
// to the GTP and the GTP RX data is passed back to the link layer.
//
// Ports:
//   clk, reset (async, active-high)
//   rx_locked, gen2, rxstatus[2:0], rxelecidle, rxbyteisaligned
//   rx_datain[15:0], rx_charisk[1:0]          GTP receive side
//   tx_datain[15:0], tx_chariskin             link-layer transmit side
//   txcomstart, txcomtype, txelecidle         GTP OOB controls
//   tx_dataout[15:0], tx_charisk              to GTP (1-cycle registered)
//   rx_dataout[15:0], rx_charisk_out          to link layer (registered)
//   rxreset, linkup, CurrentState_out[3:0], align_det_out, timeout_out
//
// Build option: define OOB_DEV_RETRY_EN to make an ALIGN-phase timeout
// re-issue COMINIT directly instead of waiting for a new COMRESET.

module oob_device_control #(
    parameter int          ALIGN_DET_NUM = 3,
    parameter logic [17:0] ALIGN_TIMEOUT = 18'h01000,
    parameter logic [17:0] WAIT_TIMEOUT  = 18'h203AD,
    parameter logic [17:0] QUIET_CYCLES  = 18'h00040,
    parameter logic [17:0] SYNC_CYCLES   = 18'h00010
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_locked,
    input  logic        gen2,
    input  logic [2:0]  rxstatus,
    input  logic        rxelecidle,
    input  logic        rxbyteisaligned,
    input  logic [15:0] rx_datain,
    input  logic [1:0]  rx_charisk,
    input  logic [15:0] tx_datain,
    input  logic        tx_chariskin,
    output logic        txcomstart,
    output logic        txcomtype,
    output logic        txelecidle,
    output logic [15:0] tx_dataout,
    output logic        tx_charisk,
    output logic [15:0] rx_dataout,
    output logic [1:0]  rx_charisk_out,
    output logic        rxreset,
    output logic        linkup,
    output logic [3:0]  CurrentState_out,
    output logic        align_det_out,
    output logic        timeout_out
);

    localparam logic [15:0] ALIGN_LO = 16'h4ABC;
    localparam logic [15:0] ALIGN_HI = 16'h7B4A;
    localparam logic [15:0] SYNC_LO  = 16'h957C;
    localparam logic [15:0] SYNC_HI  = 16'hB5B5;
    localparam logic [15:0] D10_2    = 16'h4A4A;

    localparam logic [17:0] CINIT_G1 = 18'h000A2;
    localparam logic [17:0] CINIT_G2 = 18'h00144;
    localparam logic [17:0] CWAKE_G1 = 18'h0009B;
    localparam logic [17:0] CWAKE_G2 = 18'h00136;

    localparam logic [3:0] ALIGN_NUM_MAX = 4'(ALIGN_DET_NUM);

    typedef enum logic [3:0] {
        DEV_WAIT_COMRESET = 4'd0,
        DEV_WAIT_QUIET    = 4'd1,
        DEV_COMINIT       = 4'd2,
        DEV_WAIT_COMWAKE  = 4'd3,
        DEV_COMWAKE       = 4'd4,
        DEV_WAIT_DIALTONE = 4'd5,
        DEV_SEND_ALIGN    = 4'd6,
        DEV_SEND_SYNC     = 4'd7,
        LINK_READY        = 4'd8
    } state_t;

`ifdef OOB_DEV_RETRY_EN
    localparam state_t ALIGN_ABORT = DEV_COMINIT;
`else
    localparam state_t ALIGN_ABORT = DEV_WAIT_COMRESET;
`endif

    state_t      r_state;
    state_t      w_next_state;
    logic [17:0] r_count;
    logic [15:0] r_rx_datain_r1;
    logic [1:0]  r_rx_charisk;
    logic [3:0]  r_align_num;
    logic        r_align_phase;
    logic        r_linkup;
    logic [15:0] r_tx_data;
    logic        r_tx_k;

    logic        w_comreset;
    logic        w_comwake;
    logic        w_override;
    logic        w_align_det;
    logic        w_align_word;
    logic        w_state_chg;
    logic        w_counting;
    logic        w_timeout;
    logic        w_rxreset;
    logic [17:0] w_cominit_len;
    logic [17:0] w_comwake_len;
    logic [15:0] w_tx_data;
    logic        w_tx_k;

    assign w_comreset    = (rxstatus == 3'b100);
    assign w_comwake     = (rxstatus == 3'b010);
    assign w_cominit_len = gen2 ? CINIT_G2 : CINIT_G1;
    assign w_comwake_len = gen2 ? CWAKE_G2 : CWAKE_G1;

    // ALIGN primitive arrives as 4ABC followed by 7B4A
    assign w_align_det  = (rx_datain == ALIGN_HI) &&
                          (r_rx_datain_r1 == ALIGN_LO) &&
                          rxbyteisaligned;
    assign w_align_word = (rx_datain == ALIGN_LO) ||
                          (rx_datain == ALIGN_HI);

    // A host COMRESET restarts the handshake from any post-COMINIT state
    assign w_override = w_comreset &&
                        (r_state inside {DEV_WAIT_COMWAKE, DEV_COMWAKE,
                                         DEV_WAIT_DIALTONE, DEV_SEND_ALIGN,
                                         DEV_SEND_SYNC, LINK_READY});

    assign w_counting = r_state inside {DEV_WAIT_QUIET, DEV_COMINIT,
                                        DEV_WAIT_COMWAKE, DEV_COMWAKE,
                                        DEV_SEND_ALIGN, DEV_SEND_SYNC};

    assign w_state_chg = (w_next_state != r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= DEV_WAIT_COMRESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_timeout    = 1'b0;
        w_rxreset    = 1'b0;
        case (r_state)
            DEV_WAIT_COMRESET: begin
                if (rx_locked && w_comreset)
                    w_next_state = DEV_WAIT_QUIET;
            end
            DEV_WAIT_QUIET: begin
                if (r_count == QUIET_CYCLES)
                    w_next_state = DEV_COMINIT;
            end
            DEV_COMINIT: begin
                if (r_count == w_cominit_len)
                    w_next_state = DEV_WAIT_COMWAKE;
            end
            DEV_WAIT_COMWAKE: begin
                if (w_comwake) begin
                    w_next_state = DEV_COMWAKE;
                end else if (r_count == WAIT_TIMEOUT) begin
                    w_next_state = DEV_WAIT_COMRESET;
                    w_timeout    = 1'b1;
                end
            end
            DEV_COMWAKE: begin
                if (r_count == w_comwake_len)
                    w_next_state = DEV_WAIT_DIALTONE;
            end
            DEV_WAIT_DIALTONE: begin
                if (!rxelecidle) begin
                    w_next_state = DEV_SEND_ALIGN;
                    w_rxreset    = 1'b1;
                end
            end
            DEV_SEND_ALIGN: begin
                if (r_align_num == ALIGN_NUM_MAX) begin
                    w_next_state = DEV_SEND_SYNC;
                end else if (r_count == ALIGN_TIMEOUT) begin
                    w_next_state = ALIGN_ABORT;
                    w_timeout    = 1'b1;
                end
            end
            DEV_SEND_SYNC: begin
                if (r_count == SYNC_CYCLES)
                    w_next_state = LINK_READY;
            end
            LINK_READY: begin
                w_next_state = LINK_READY;
            end
            default: begin
                w_next_state = DEV_WAIT_COMRESET;
            end
        endcase
        if (w_override) begin
            w_next_state = DEV_WAIT_QUIET;
            w_timeout    = 1'b0;
            w_rxreset    = 1'b0;
        end
    end

    // Quiet period restarts while the host keeps signalling COMRESET
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_state_chg) begin
            r_count <= '0;
        end else if (r_state == DEV_WAIT_QUIET && w_comreset) begin
            r_count <= '0;
        end else if (w_counting) begin
            r_count <= r_count + 18'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_align_num <= '0;
        end else if (w_state_chg || !w_align_word) begin
            r_align_num <= '0;
        end else if (w_align_det && r_align_num != ALIGN_NUM_MAX) begin
            r_align_num <= r_align_num + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_align_phase <= 1'b0;
        end else if (r_state == DEV_SEND_ALIGN) begin
            r_align_phase <= ~r_align_phase;
        end else begin
            r_align_phase <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_linkup <= 1'b0;
        end else begin
            r_linkup <= (r_state == LINK_READY) && !rxelecidle;
        end
    end

    // SYNC pairs use the count parity; it is zero on entry to the state
    always_comb begin
        w_tx_data = D10_2;
        w_tx_k    = 1'b0;
        if (r_linkup) begin
            w_tx_data = tx_datain;
            w_tx_k    = tx_chariskin;
        end else if (r_state == DEV_SEND_ALIGN) begin
            w_tx_data = r_align_phase ? ALIGN_HI : ALIGN_LO;
            w_tx_k    = ~r_align_phase;
        end else if (r_state == DEV_SEND_SYNC) begin
            w_tx_data = r_count[0] ? SYNC_HI : SYNC_LO;
            w_tx_k    = ~r_count[0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tx_data      <= '0;
            r_tx_k         <= 1'b0;
            r_rx_datain_r1 <= '0;
            r_rx_charisk   <= '0;
        end else begin
            r_tx_data      <= w_tx_data;
            r_tx_k         <= w_tx_k;
            r_rx_datain_r1 <= rx_datain;
            r_rx_charisk   <= rx_charisk;
        end
    end

    always_comb begin
        txcomstart = 1'b0;
        txcomtype  = 1'b0;
        txelecidle = 1'b1;
        case (r_state)
            DEV_COMINIT: begin
                txcomstart = 1'b1;
            end
            DEV_COMWAKE: begin
                txcomstart = 1'b1;
                txcomtype  = 1'b1;
            end
            DEV_SEND_ALIGN, DEV_SEND_SYNC, LINK_READY: begin
                txelecidle = 1'b0;
            end
            default: begin
            end
        endcase
    end

    assign tx_dataout       = r_tx_data;
    assign tx_charisk       = r_tx_k;
    assign rx_dataout       = r_rx_datain_r1;
    assign rx_charisk_out   = r_rx_charisk;
    assign rxreset          = w_rxreset;
    assign linkup           = r_linkup;
    assign CurrentState_out = r_state;
    assign align_det_out    = w_align_det;
    assign timeout_out      = w_timeout;

endmodule
